dmem_pipe: RTL
==============

DMEM_PIPE -- requirements
Module: dmem_pipe

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be 32 or 64.
REQ-002 Parameter DEPTH, default 64, number of words; SHALL be a power of 2, 4..4096.
REQ-003 Parameter LATENCY, default 1, request-accept to response, in cycles; SHALL be 1..4.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  reset is synchronous and active-low; asserted (0) sampled on a rising clk edge resets the block.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block accepts a request this cycle.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  access size: 00 byte, 01 half, 10 word32, 11 dword64.
REQ-010 req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-011 req_addr  in  32  byte address.
REQ-012 req_wdata  in  DATA_W  store data, right-aligned (the low bytes hold the data).
REQ-013 rsp_valid  out  1  response strobe, one cycle per accepted request.
REQ-014 rsp_rdata  out  DATA_W  load data, extended to DATA_W; 0 for stores and errors.
REQ-015 rsp_err  out  1  accepted request was illegal; qualified by rsp_valid.

Function
REQ-016 Definitions: BYTES = DATA_W/8; LSB = log2(BYTES); word index = req_addr[LSB +: log2(DEPTH)]; byte offset = req_addr[LSB-1:0].
REQ-017 Handshake: a request is accepted on a rising edge where req_valid and req_ready are both 1; there is no response backpressure.
REQ-018 State machine: CLEAR -> RUN.
  - CLEAR: 9-bit-or-wider counter writes 0 to word 0..DEPTH-1, one word per cycle; req_ready = 0.
  - After writing word DEPTH-1, go to RUN.
  - RUN: req_ready = 1 every cycle.
  - No other transitions except reset.
REQ-019 Illegal request (any of the following) SHALL NOT modify memory and SHALL respond with rsp_err = 1, rsp_rdata = 0:
  - size 11 when DATA_W = 32;
  - misalignment: offset not a multiple of the access size in bytes;
  - req_addr bits above LSB + log2(DEPTH) nonzero.
REQ-020 Legal store: on the accept edge, only the bytes [offset, offset + size_bytes) of the indexed word are written, from req_wdata low bytes; other bytes are unchanged.
REQ-021 Legal load: read the indexed word at accept; shift right by offset*8; keep size_bytes bytes; extend per req_signed.
REQ-022 Response SHALL appear exactly LATENCY cycles after the accept edge, through a LATENCY-deep valid/data/err pipeline; back-to-back accepts yield back-to-back responses.
REQ-023 A store acknowledges with rsp_valid = 1, rsp_err = 0, rsp_rdata = 0.
REQ-024 Read-after-write: a load accepted the cycle after a store to the same word SHALL return the post-store data.
REQ-025 Responses SHALL return in acceptance order.

Reset
REQ-026 While reset = 0 at an edge:
  - state becomes CLEAR, the clear counter is set to 0, all pipeline valid bits are cleared;
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, req_ready = 0.
REQ-027 Reset mid-operation: in-flight responses are discarded; a partially completed CLEAR sweep restarts at word 0.
REQ-028 The first RUN cycle SHALL be DEPTH cycles after reset deasserts.

Structure
REQ-029 A shared package SHALL hold:
  - the size encodings (SZ_B, SZ_H, SZ_W, SZ_D);
  - the state enum (CLEAR, RUN);
  - function size_bytes(size).
REQ-030 The block SHALL have one sub-module, dmem_lane_fmt (combinational), which takes size, offset, signed and word and produces the extended load data plus the store byte-enable mask; the rest stays in dmem_pipe.
REQ-031 The memory is a single-port register array of DEPTH x DATA_W, with no inferred reset on the array.

Verification
REQ-032 Reset pulse, then hold req_valid = 1 -> req_ready = 0 for exactly 64 cycles, 1 thereafter; a load of 0x0 returns 0x00000000.
REQ-033 Store word 0xDEADBEEF @0x10, then the next cycle load byte signed @0x13 and byte unsigned @0x13 -> 0xFFFFFFDE, then 0x000000DE, each LATENCY cycles after its accept.
REQ-034 Store half 0x1234 @0x22 over a word previously 0xAAAAAAAA; load word @0x20 -> 0x1234AAAA.
REQ-035 Load half @0x21, load word @0x102 (DEPTH = 64), store size 11 with DATA_W = 32 -> three rsp_err = 1 responses; memory unchanged.
REQ-036 LATENCY = 3, 5 back-to-back loads -> 5 consecutive rsp_valid cycles starting 3 cycles after the first accept, in order.
REQ-037 Reset asserted with 2 responses in flight -> no rsp_valid after reset; the CLEAR sweep restarts and earlier stored data reads back 0.

Source files
------------

// File: rtl/dmem_pipe_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pipe_pkg
// Shared definitions for the dmem_pipe data memory:
//   SZ_B/SZ_H/SZ_W/SZ_D  access-size encodings carried on req_size
//   state_t              controller state (CLEAR sweep, then RUN)
//   size_bytes()         access size in bytes for a size encoding
// ---------------------------------------------------------------------------
package dmem_pipe_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // 1, 2, 4 or 8 bytes.
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/dmem_pipe_lane_fmt.sv
// ---------------------------------------------------------------------------
// dmem_lane_fmt
// Purely combinational byte-lane formatter.
//   size    access size encoding
//   offset  byte offset of the access inside the memory word
//   sign    1 = sign-extend load data, 0 = zero-extend
//   word    full memory word (load source)
//   ld_data word shifted down by offset, trimmed to the access size and
//           extended to DATA_W
//   st_be   byte-enable mask covering bytes [offset, offset + size)
// ---------------------------------------------------------------------------
module dmem_lane_fmt
    import dmem_pipe_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int BYTES  = DATA_W / 8,
    localparam int OFF_W  = $clog2(BYTES)
) (
    input  logic [1:0]        size,
    input  logic [OFF_W-1:0]  offset,
    input  logic              sign,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] ld_data,
    output logic [BYTES-1:0]  st_be
);

    logic [DATA_W-1:0] shifted;
    logic [3:0]        nbytes;
    logic              msb;
    logic              ext;

    assign shifted = word >> {offset, 3'b000};
    assign nbytes  = size_bytes(size);

    // Top bit of the accessed field once it sits at bit 0.
    always_comb begin
        msb = 1'b0;
        case (size)
            SZ_B:    msb = shifted[7];
            SZ_H:    msb = shifted[15];
            SZ_W:    msb = shifted[31];
            default: msb = shifted[DATA_W-1];
        endcase
    end

    assign ext = sign & msb;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            localparam logic [4:0] LANE = 5'(gi);
            // Lanes inside the access keep their byte, the rest carry the extension.
            assign ld_data[gi*8 +: 8] = (LANE < {1'b0, nbytes}) ? shifted[gi*8 +: 8] : {8{ext}};
            assign st_be[gi] = (LANE >= 5'(offset)) && (LANE < (5'(offset) + {1'b0, nbytes}));
        end
    endgenerate

endmodule

// File: rtl/dmem_pipe.sv
// ---------------------------------------------------------------------------
// dmem_pipe
// Single-port data memory with a fixed-latency response pipeline.
// After reset the array is swept to zero (one word per cycle, req_ready low),
// then requests are accepted every cycle.
//   clk        clock, all state on rising edge
//   reset      synchronous, active-low
//   req_*      request: valid/ready handshake, we, size, signed, addr, wdata
//   rsp_valid  one strobe per accepted request, LATENCY cycles after accept
//   rsp_rdata  extended load data (0 for stores and errors)
//   rsp_err    request was illegal (bad size, misaligned or out of range)
// ---------------------------------------------------------------------------
module dmem_pipe
    import dmem_pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (IDX_W > 9) ? IDX_W : 9;

    // ---------------- controller ----------------
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] clr_cnt_reg, clr_cnt_next;

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            CLEAR: begin
                clr_cnt_next = clr_cnt_reg + CNT_W'(1);
                if (clr_cnt_reg == CNT_W'(DEPTH - 1)) begin
                    state_next = RUN;
                end
            end
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    assign req_ready = (state_reg == RUN);

    // ---------------- request decode ----------------
    logic              accept;
    logic [IDX_W-1:0]  word_idx;
    logic [LSB-1:0]    byte_off;
    logic [31:0]       addr_hi;
    logic [3:0]        req_nbytes;
    logic              req_err;
    logic              do_write;
    logic [DATA_W-1:0] wdata_sh;
    logic [BYTES-1:0]  st_be;
    logic [DATA_W-1:0] st_ld_unused;

    // An edge that resets the block must not also commit a request.
    assign accept     = req_valid & req_ready & reset;
    assign word_idx   = req_addr[LSB +: IDX_W];
    assign byte_off   = req_addr[LSB-1:0];
    assign addr_hi    = req_addr >> (LSB + IDX_W);
    assign req_nbytes = size_bytes(req_size);

    assign req_err = ((req_size == SZ_D) && (DATA_W == 32))
                   || ((4'(byte_off) & (req_nbytes - 4'd1)) != 4'd0)
                   || (addr_hi != 32'd0);

    assign do_write = accept & req_we & ~req_err;
    assign wdata_sh = req_wdata << {byte_off, 3'b000};

    // Store side only needs the byte-enable mask.
    dmem_lane_fmt #(.DATA_W(DATA_W)) u_st_fmt (
        .size    (req_size),
        .offset  (byte_off),
        .sign    (req_signed),
        .word    ('0),
        .ld_data (st_ld_unused),
        .st_be   (st_be)
    );

    // ---------------- memory array ----------------
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (state_reg == CLEAR) begin
            mem[clr_cnt_reg[IDX_W-1:0]] <= '0;
        end else if (do_write) begin
            for (int b = 0; b < BYTES; b++) begin
                if (st_be[b]) begin
                    mem[word_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- stage 0: registered read ----------------
    // The read is taken at the accept edge, so a load right after a store
    // to the same word already sees the stored bytes.
    logic              s0_valid_reg;
    logic              s0_err_reg;
    logic              ld_fmt_reg;
    logic [1:0]        ld_size_reg;
    logic [LSB-1:0]    ld_off_reg;
    logic              ld_sign_reg;
    logic [DATA_W-1:0] rd_word_reg;
    logic [DATA_W-1:0] ld_data;
    logic [BYTES-1:0]  ld_be_unused;
    logic [DATA_W-1:0] s0_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s0_valid_reg <= 1'b0;
        end else begin
            s0_valid_reg <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word_reg <= mem[word_idx];
            ld_size_reg <= req_size;
            ld_off_reg  <= byte_off;
            ld_sign_reg <= req_signed;
            s0_err_reg  <= req_err;
            ld_fmt_reg  <= ~req_we & ~req_err;
        end
    end

    dmem_lane_fmt #(.DATA_W(DATA_W)) u_ld_fmt (
        .size    (ld_size_reg),
        .offset  (ld_off_reg),
        .sign    (ld_sign_reg),
        .word    (rd_word_reg),
        .ld_data (ld_data),
        .st_be   (ld_be_unused)
    );

    // Stores and errors return zero data.
    assign s0_data = ld_fmt_reg ? ld_data : '0;

    logic unused_fmt;
    assign unused_fmt = ^{st_ld_unused, ld_be_unused};

    // ---------------- remaining latency stages ----------------
    logic              out_valid;
    logic              out_err;
    logic [DATA_W-1:0] out_data;

    generate
        if (LATENCY == 1) begin : g_lat1
            assign out_valid = s0_valid_reg;
            assign out_err   = s0_err_reg;
            assign out_data  = s0_data;
        end else begin : g_latn
            localparam int N = LATENCY - 1;
            logic              valid_pipe_reg [N];
            logic              err_pipe_reg   [N];
            logic [DATA_W-1:0] data_pipe_reg  [N];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < N; i++) begin
                        valid_pipe_reg[i] <= 1'b0;
                    end
                end else begin
                    valid_pipe_reg[0] <= s0_valid_reg;
                    for (int i = 1; i < N; i++) begin
                        valid_pipe_reg[i] <= valid_pipe_reg[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                err_pipe_reg[0]  <= s0_err_reg;
                data_pipe_reg[0] <= s0_data;
                for (int i = 1; i < N; i++) begin
                    err_pipe_reg[i]  <= err_pipe_reg[i-1];
                    data_pipe_reg[i] <= data_pipe_reg[i-1];
                end
            end

            assign out_valid = valid_pipe_reg[N-1];
            assign out_err   = err_pipe_reg[N-1];
            assign out_data  = data_pipe_reg[N-1];
        end
    endgenerate

    // Payload registers carry no reset; qualifying with valid keeps the
    // outputs at zero whenever no response is presented.
    assign rsp_valid = out_valid;
    assign rsp_err   = out_valid & out_err;
    assign rsp_rdata = out_valid ? out_data : '0;

endmodule
